// File: rtl/decode_rob_issue_queue.sv
// decode_rob_issue_queue: dual-lane in-order uop buffer between decoder and ROB dispatch; enq lanes (valid/payload in, ready out), deq lanes (valid/payload out, ready in), wfi/trap/ret controls, occupancy out
module decode_rob_issue_queue #(
  parameter int DEPTH = 8,
  parameter int PAYLOAD_W = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     global_wfi_i,
  input  logic                     global_trap_i,
  input  logic                     global_ret_i,
  input  logic                     enq_valid_first_i,
  input  logic                     enq_valid_second_i,
  input  logic [PAYLOAD_W-1:0]     enq_payload_first_i,
  input  logic [PAYLOAD_W-1:0]     enq_payload_second_i,
  output logic                     enq_ready_first_o,
  output logic                     enq_ready_second_o,
  output logic                     deco_rob_req_valid_first_o,
  output logic                     deco_rob_req_valid_second_o,
  input  logic                     deco_rob_req_ready_first_i,
  input  logic                     deco_rob_req_ready_second_i,
  output logic [PAYLOAD_W-1:0]     deq_payload_first_o,
  output logic [PAYLOAD_W-1:0]     deq_payload_second_o,
  output logic [$clog2(DEPTH):0]   occupancy_o
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] head_q, head_d, tail_q, tail_d, count;
  logic [AW-1:0] t0, t1, h0, h1;
  logic [PAYLOAD_W-1:0] mem_q [DEPTH];
  logic enq0, enq1, deq0, deq1, flush;
  assign count = tail_q - head_q;
  assign occupancy_o = count;
  assign flush = global_trap_i | global_ret_i;
  assign t0 = tail_q[AW-1:0];
  assign t1 = t0 + AW'(1);
  assign h0 = head_q[AW-1:0];
  assign h1 = h0 + AW'(1);
  assign enq_ready_first_o = count < (AW+1)'(DEPTH);
  assign enq_ready_second_o = count < (AW+1)'(DEPTH - 1);
  assign deco_rob_req_valid_first_o = (count != '0) & ~global_wfi_i;
  assign deco_rob_req_valid_second_o = (count > (AW+1)'(1)) & ~global_wfi_i;
  assign enq0 = enq_valid_first_i & enq_ready_first_o;
  assign enq1 = enq0 & enq_valid_second_i & enq_ready_second_o;
  assign deq0 = deco_rob_req_valid_first_o & deco_rob_req_ready_first_i;
  assign deq1 = deq0 & deco_rob_req_valid_second_o & deco_rob_req_ready_second_i;
  assign deq_payload_first_o = mem_q[h0];
  assign deq_payload_second_o = mem_q[h1];
  always_comb begin
    head_d = flush ? '0 : head_q + (AW+1)'(deq0) + (AW+1)'(deq1);
    tail_d = flush ? '0 : tail_q + (AW+1)'(enq0) + (AW+1)'(enq1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end
  // storage is unreset; pointers alone define which entries are live
  always_ff @(posedge clk) begin
    if (!rst && !flush && enq0) mem_q[t0] <= enq_payload_first_i;
    if (!rst && !flush && enq1) mem_q[t1] <= enq_payload_second_i;
  end
endmodule

// File: tb/tb_decode_rob_issue_queue.sv
// tb_decode_rob_issue_queue: directed and scoreboarded checks of the dual-lane issue queue
module tb_decode_rob_issue_queue;
  localparam int PW = 256;
  logic clk = 0, rst = 1, wfi = 0, trap = 0, ret = 0;
  logic vin0 = 0, vin1 = 0, r0 = 0, r1 = 0;
  logic [PW-1:0] pf_in = '0, ps_in = '0, pf, ps;
  logic erf, ers, vf, vs;
  logic [3:0] occ;
  int n_cmp = 0, n_err = 0;
  logic [PW-1:0] sb [$];
  int mc, sent, n;
  bit e0, e1, d0, d1, rr0, rr1;

  decode_rob_issue_queue #(.DEPTH(8), .PAYLOAD_W(PW)) dut (
    .clk(clk), .rst(rst), .global_wfi_i(wfi), .global_trap_i(trap), .global_ret_i(ret),
    .enq_valid_first_i(vin0), .enq_valid_second_i(vin1),
    .enq_payload_first_i(pf_in), .enq_payload_second_i(ps_in),
    .enq_ready_first_o(erf), .enq_ready_second_o(ers),
    .deco_rob_req_valid_first_o(vf), .deco_rob_req_valid_second_o(vs),
    .deco_rob_req_ready_first_i(r0), .deco_rob_req_ready_second_i(r1),
    .deq_payload_first_o(pf), .deq_payload_second_o(ps), .occupancy_o(occ)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic enq(input bit two, input logic [PW-1:0] a, input logic [PW-1:0] b);
    vin0 = 1; vin1 = two; pf_in = a; ps_in = b;
    tick();
    vin0 = 0; vin1 = 0;
  endtask

  initial begin
    tick(); tick();
    rst = 0;
    chk("rst_occ", occ, 0);
    chk("rst_vf", vf, 0);
    chk("rst_vs", vs, 0);
    chk("rst_erf", erf, 1);
    chk("rst_ers", ers, 1);
    // dual enqueue, one-cycle latency, dual dequeue
    enq(1, 'hA, 'hB);
    chk("ab_vf", vf, 1);
    chk("ab_vs", vs, 1);
    chk("ab_pf", pf, 'hA);
    chk("ab_ps", ps, 'hB);
    chk("ab_occ", occ, 2);
    r0 = 1; r1 = 1; tick(); r0 = 0; r1 = 0;
    chk("ab_drain_occ", occ, 0);
    chk("ab_drain_vf", vf, 0);
    chk("ab_drain_vs", vs, 0);
    // partial accept
    enq(1, 'hC, 'hD);
    enq(0, 'hE, '0);
    chk("part_occ3", occ, 3);
    r0 = 1; tick(); r0 = 0;
    chk("part_occ2", occ, 2);
    chk("part_pf", pf, 'hD);
    chk("part_ps", ps, 'hE);
    r1 = 1; tick(); r1 = 0;
    chk("part_r1only_occ", occ, 2);
    chk("part_r1only_pf", pf, 'hD);
    r0 = 1; r1 = 1; tick(); r0 = 0; r1 = 0;
    chk("part_drain", occ, 0);
    // fill to full, wrapping index 7 -> 0
    for (int i = 0; i < 4; i++) enq(1, PW'(16 + 2 * i), PW'(17 + 2 * i));
    chk("full_occ", occ, 8);
    chk("full_erf", erf, 0);
    chk("full_ers", ers, 0);
    r0 = 1; tick(); r0 = 0;
    chk("m1_occ", occ, 7);
    chk("m1_erf", erf, 1);
    chk("m1_ers", ers, 0);
    chk("m1_pf", pf, 17);
    enq(1, 'h20, 'h21);
    chk("m1_lane1_rej_occ", occ, 8);
    r0 = 1; r1 = 1;
    tick(); tick(); tick();
    chk("wrap_occ", occ, 2);
    chk("wrap_pf", pf, 23);
    chk("wrap_ps", ps, 'h20);
    tick(); r0 = 0; r1 = 0;
    chk("wrap_empty", occ, 0);
    // random stream against a scoreboard
    mc = 0; sent = 0;
    for (int cyc = 0; cyc < 400 && (sent < 40 || sb.size() > 0); cyc++) begin
      n = (sent < 40) ? int'($urandom_range(0, 2)) : 0;
      vin0 = n >= 1;
      vin1 = n == 2 && sent + 1 < 40;
      pf_in = PW'('h1000 + sent);
      ps_in = PW'('h1001 + sent);
      rr0 = $urandom_range(0, 1) == 1; rr1 = $urandom_range(0, 1) == 1;
      r0 = rr0; r1 = rr1;
      e0 = vin0 && mc < 8;
      e1 = e0 && vin1 && mc <= 6;
      d0 = mc >= 1 && rr0;
      d1 = d0 && mc >= 2 && rr1;
      #1;
      chk("rnd_vf", vf, PW'(mc >= 1));
      chk("rnd_vs", vs, PW'(mc >= 2));
      if (d0) chk("rnd_pf", pf, sb[0]);
      if (d1) chk("rnd_ps", ps, sb[1]);
      tick();
      if (d0) void'(sb.pop_front());
      if (d1) void'(sb.pop_front());
      if (e0) sb.push_back(pf_in);
      if (e1) sb.push_back(ps_in);
      mc = mc + int'(e0) + int'(e1) - int'(d0) - int'(d1);
      sent = sent + int'(e0) + int'(e1);
      chk("rnd_occ", occ, PW'(mc));
    end
    vin0 = 0; vin1 = 0; r0 = 0; r1 = 0;
    chk("rnd_done", PW'(sent == 40 && sb.size() == 0), 1);
    // flush via trap, then via ret
    for (int k = 0; k < 2; k++) begin
      enq(1, 'h50, 'h51);
      enq(1, 'h52, 'h53);
      enq(0, 'h54, '0);
      chk("fl_pre_occ", occ, 5);
      trap = k == 0; ret = k == 1;
      vin0 = 1; vin1 = 1; r0 = 1; r1 = 1;
      tick();
      trap = 0; ret = 0; vin0 = 0; vin1 = 0; r0 = 0; r1 = 0;
      chk("fl_occ", occ, 0);
      chk("fl_vf", vf, 0);
      chk("fl_vs", vs, 0);
      chk("fl_erf", erf, 1);
      chk("fl_ers", ers, 1);
    end
    // WFI holds valids low, contents preserved, enqueue continues
    enq(1, 'h30, 'h31);
    enq(0, 'h32, '0);
    wfi = 1; r0 = 1; r1 = 1;
    vin0 = 1; pf_in = 'h33;
    #1;
    chk("wfi_vf0", vf, 0);
    chk("wfi_vs0", vs, 0);
    tick();
    vin0 = 0;
    chk("wfi_occ0", occ, 4);
    for (int i = 0; i < 3; i++) begin
      chk("wfi_vf", vf, 0);
      chk("wfi_vs", vs, 0);
      tick();
      chk("wfi_occ", occ, 4);
    end
    wfi = 0;
    #1;
    chk("wake_vf", vf, 1);
    chk("wake_pf", pf, 'h30);
    chk("wake_ps", ps, 'h31);
    tick();
    r0 = 0; r1 = 0;
    chk("wake_occ", occ, 2);
    chk("wake_pf2", pf, 'h32);
    chk("wake_ps2", ps, 'h33);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
